// File: rtl/cu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cu_pkg : opcodes, ALU codes and FSM states for control_unit_mc       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cu_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [5:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_MOV   = 6'd3,
        OP_DIV   = 6'd4,
        OP_MUL   = 6'd5,
        OP_AND   = 6'd6,
        OP_OR    = 6'd7,
        OP_LOAD  = 6'd8,
        OP_STORE = 6'd9
    } opcode_e;

    localparam logic [5:0] ALU_NONE = 6'd0;
    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_DIV  = 6'd4;
    localparam logic [5:0] ALU_MUL  = 6'd5;
    localparam logic [5:0] ALU_AND  = 6'd6;
    localparam logic [5:0] ALU_OR   = 6'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_WB     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/control_unit_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit_mc_if : instruction handshake and datapath control bus  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface control_unit_mc_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 8
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [5:0]         alu_ctrl;
    logic [REG_AW-1:0]  r1;
    logic [REG_AW-1:0]  r2;
    logic [REG_AW-1:0]  rd;
    logic [IMM_W-1:0]   i1;
    logic [IMM_W-1:0]   i2;
    logic               alu_start;
    logic               alu_done;
    logic               rwe;
    logic               rwe2;
    logic               mwe;
    logic               illegal;
    logic               fault;
    logic               busy;

    modport master (
        output instr_valid, instr, alu_done,
        input  instr_ready, alu_ctrl, r1, r2, rd, i1, i2,
        input  alu_start, rwe, rwe2, mwe, illegal, fault, busy
    );

    modport slave (
        input  instr_valid, instr, alu_done,
        output instr_ready, alu_ctrl, r1, r2, rd, i1, i2,
        output alu_start, rwe, rwe2, mwe, illegal, fault, busy
    );
endinterface
`default_nettype wire

// File: rtl/cu_field_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cu_field_decode : slices instruction fields and classifies opcode    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cu_field_decode
    import cu_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int REG_AW    = 3,
    parameter int IMM_W     = 8,
    parameter int MUL_MULTI = 1
) (
    input  wire logic [INSTR_W-1:0] i_instr,
    output logic      [5:0]         o_alu_ctrl,
    output logic      [REG_AW-1:0]  o_rd,
    output logic      [REG_AW-1:0]  o_r1,
    output logic      [REG_AW-1:0]  o_r2,
    output logic      [IMM_W-1:0]   o_i1,
    output logic      [IMM_W-1:0]   o_i2,
    output logic                    o_legal,
    output logic                    o_nop,
    output logic                    o_multi,
    output logic                    o_sel_rwe,
    output logic                    o_sel_rwe2,
    output logic                    o_sel_mwe
);
    localparam int c_RD_MSB = INSTR_W - OPC_W - 1;
    localparam int c_R1_MSB = c_RD_MSB - REG_AW;
    localparam int c_R2_MSB = c_R1_MSB - REG_AW;
    localparam int c_I1_MSB = c_R2_MSB - REG_AW;
    localparam int c_I2_MSB = c_I1_MSB - IMM_W;
    localparam int c_PAD_W  = INSTR_W - OPC_W - 3*REG_AW - 2*IMM_W;

    logic [OPC_W-1:0] w_op;

    assign w_op = i_instr[INSTR_W-1 -: OPC_W];
    assign o_rd = i_instr[c_RD_MSB -: REG_AW];
    assign o_r1 = i_instr[c_R1_MSB -: REG_AW];
    assign o_r2 = i_instr[c_R2_MSB -: REG_AW];
    assign o_i1 = i_instr[c_I1_MSB -: IMM_W];
    assign o_i2 = i_instr[c_I2_MSB -: IMM_W];

    // Low-order bits below the last immediate carry no meaning.
    generate
        if (c_PAD_W > 0) begin : g_pad
            logic w_unused_pad;
            assign w_unused_pad = ^i_instr[c_PAD_W-1:0];
        end
    endgenerate

    always_comb begin
        o_alu_ctrl = ALU_NONE;
        o_legal    = 1'b0;
        o_nop      = 1'b0;
        o_multi    = 1'b0;
        o_sel_rwe  = 1'b0;
        o_sel_rwe2 = 1'b0;
        o_sel_mwe  = 1'b0;
        case (w_op)
            OP_NOP:   begin o_legal = 1'b1; o_nop = 1'b1; end
            OP_ADD:   begin o_legal = 1'b1; o_alu_ctrl = ALU_ADD; o_sel_rwe = 1'b1; end
            OP_SUB:   begin o_legal = 1'b1; o_alu_ctrl = ALU_SUB; o_sel_rwe = 1'b1; end
            OP_MOV:   begin o_legal = 1'b1; o_sel_rwe2 = 1'b1; end
            OP_DIV:   begin o_legal = 1'b1; o_alu_ctrl = ALU_DIV; o_sel_rwe = 1'b1; o_multi = 1'b1; end
            OP_MUL:   begin
                o_legal    = 1'b1;
                o_alu_ctrl = ALU_MUL;
                o_sel_rwe  = 1'b1;
                o_multi    = (MUL_MULTI != 0);
            end
            OP_AND:   begin o_legal = 1'b1; o_alu_ctrl = ALU_AND; o_sel_rwe = 1'b1; end
            OP_OR:    begin o_legal = 1'b1; o_alu_ctrl = ALU_OR;  o_sel_rwe = 1'b1; end
            OP_LOAD:  begin o_legal = 1'b1; o_sel_rwe = 1'b1; end
            OP_STORE: begin o_legal = 1'b1; o_sel_mwe = 1'b1; end
            default:  ;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/control_unit_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit_mc : multi-cycle instruction sequencer with ALU wait    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int REG_AW    = 3,
    parameter int IMM_W     = 8,
    parameter int MUL_MULTI = 1,
    parameter int WAIT_MAX  = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    control_unit_mc_if.slave bus
);
    localparam int                 c_CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_MAX - 1);

    state_e               r_state;
    state_e               w_next;
    logic [INSTR_W-1:0]   r_instr;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [5:0]           w_alu_ctrl;
    logic [REG_AW-1:0]    w_rd, w_r1, w_r2;
    logic [IMM_W-1:0]     w_i1, w_i2;
    logic                 w_legal, w_nop, w_multi;
    logic                 w_sel_rwe, w_sel_rwe2, w_sel_mwe;
    logic                 w_start, w_illegal, w_fault, w_rwe, w_rwe2, w_mwe;

    // Fields are decoded from the captured word so they are visible from DECODE onward.
    cu_field_decode #(
        .INSTR_W   (INSTR_W),
        .REG_AW    (REG_AW),
        .IMM_W     (IMM_W),
        .MUL_MULTI (MUL_MULTI)
    ) u_dec (
        .i_instr    (r_instr),
        .o_alu_ctrl (w_alu_ctrl),
        .o_rd       (w_rd),
        .o_r1       (w_r1),
        .o_r2       (w_r2),
        .o_i1       (w_i1),
        .o_i2       (w_i2),
        .o_legal    (w_legal),
        .o_nop      (w_nop),
        .o_multi    (w_multi),
        .o_sel_rwe  (w_sel_rwe),
        .o_sel_rwe2 (w_sel_rwe2),
        .o_sel_mwe  (w_sel_mwe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.instr_valid) begin
                r_instr <= bus.instr;
            end
            r_cnt <= (r_state == S_WAIT) ? r_cnt + c_CNT_W'(1) : '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_illegal = 1'b0;
        w_fault   = 1'b0;
        w_rwe     = 1'b0;
        w_rwe2    = 1'b0;
        w_mwe     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_illegal = 1'b1;
                    w_next    = S_IDLE;
                end else if (w_nop) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_multi) begin
                    w_start = 1'b1;
                    w_next  = S_WAIT;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WAIT: begin
                // A done arriving on the last allowed cycle still wins over the timeout.
                if (bus.alu_done) begin
                    w_next = S_WB;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_fault = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_WB: begin
                w_rwe  = w_sel_rwe;
                w_rwe2 = w_sel_rwe2;
                w_mwe  = w_sel_mwe;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Reset masks every control output so an abandoned instruction never strobes.
    assign bus.instr_ready = (r_state == S_IDLE) && !rst;
    assign bus.busy        = (r_state != S_IDLE) && !rst;
    assign bus.alu_start   = w_start   && !rst;
    assign bus.illegal     = w_illegal && !rst;
    assign bus.fault       = w_fault   && !rst;
    assign bus.rwe         = w_rwe     && !rst;
    assign bus.rwe2        = w_rwe2    && !rst;
    assign bus.mwe         = w_mwe     && !rst;
    assign bus.alu_ctrl    = w_alu_ctrl;
    assign bus.rd          = w_rd;
    assign bus.r1          = w_r1;
    assign bus.r2          = w_r2;
    assign bus.i1          = w_i1;
    assign bus.i2          = w_i2;
endmodule
`default_nettype wire

// File: tb/tb_control_unit_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_unit_mc : directed self-checking bench for control_unit_mc|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_control_unit_mc;
    import cu_pkg::*;

    localparam logic [5:0] P_RWE   = 6'b100000;
    localparam logic [5:0] P_RWE2  = 6'b010000;
    localparam logic [5:0] P_MWE   = 6'b001000;
    localparam logic [5:0] P_START = 6'b000100;
    localparam logic [5:0] P_ILL   = 6'b000010;
    localparam logic [5:0] P_FLT   = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        done0;
    logic        done1;
    logic [31:0] instr;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    control_unit_mc_if #(.INSTR_W(32), .REG_AW(3), .IMM_W(8)) bus0 ();
    control_unit_mc_if #(.INSTR_W(32), .REG_AW(3), .IMM_W(8)) bus1 ();

    assign bus0.instr_valid = valid;
    assign bus0.instr       = instr;
    assign bus0.alu_done    = done0;
    assign bus1.instr_valid = valid;
    assign bus1.instr       = instr;
    assign bus1.alu_done    = done1;

    // dut0: multi-cycle MUL, long timeout; dut1: single-cycle MUL, short timeout.
    control_unit_mc #(.INSTR_W(32), .REG_AW(3), .IMM_W(8), .MUL_MULTI(1), .WAIT_MAX(64))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    control_unit_mc #(.INSTR_W(32), .REG_AW(3), .IMM_W(8), .MUL_MULTI(0), .WAIT_MAX(8))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [5:0] p0, p1;
    assign p0 = {bus0.rwe, bus0.rwe2, bus0.mwe, bus0.alu_start, bus0.illegal, bus0.fault};
    assign p1 = {bus1.rwe, bus1.rwe2, bus1.mwe, bus1.alu_start, bus1.illegal, bus1.fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] r1, input logic [2:0] r2,
                                       input logic [7:0] i1, input logic [7:0] i2);
        return {op, rd, r1, r2, i1, i2, 1'b0};
    endfunction

    task automatic run_short(input string tag, input logic [5:0] op,
                             input logic [5:0] ctrl, input logic [5:0] p3);
        valid = 1'b1;
        instr = mk(op, 3'd1, 3'd6, 3'd7, 8'h12, 8'h34);
        #1;
        check({tag, " ready N"}, 32'(bus0.instr_ready), 32'd1);
        cyc();
        valid = 1'b0;
        #1;
        check({tag, " alu_ctrl"}, 32'(bus0.alu_ctrl), 32'(ctrl));
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("%s dut0 pulses N+%0d", tag, c), 32'(p0), (c == 3) ? 32'(p3) : 32'd0);
            check($sformatf("%s dut1 pulses N+%0d", tag, c), 32'(p1), (c == 3) ? 32'(p3) : 32'd0);
            if (c < 4) cyc();
        end
        check({tag, " ready N+4"}, 32'(bus0.instr_ready), 32'd1);
    endtask

    task automatic run_two(input string tag, input logic [5:0] op, input logic [5:0] pexp);
        valid = 1'b1;
        instr = mk(op, 3'd2, 3'd3, 3'd4, 8'h01, 8'h02);
        #1;
        cyc();
        valid = 1'b0;
        #1;
        check({tag, " pulses N+1"}, 32'(p0), 32'(pexp));
        check({tag, " dut1 pulses N+1"}, 32'(p1), 32'(pexp));
        check({tag, " busy N+1"}, 32'(bus0.busy), 32'd1);
        cyc();
        check({tag, " pulses N+2"}, 32'(p0), 32'd0);
        check({tag, " ready N+2"}, 32'(bus0.instr_ready), 32'd1);
        check({tag, " busy N+2"}, 32'(bus0.busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        instr = '0;

        // Reset
        cyc();
        check("rst ready", 32'(bus0.instr_ready), 32'd0);
        check("rst busy", 32'(bus0.busy), 32'd0);
        check("rst pulses", 32'(p0), 32'd0);
        check("rst alu_ctrl", 32'(bus0.alu_ctrl), 32'd0);
        check("rst fields", {bus0.rd, bus0.r1, bus0.r2, bus0.i1, bus0.i2}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check("post-rst ready", 32'(bus0.instr_ready), 32'd1);
        check("post-rst busy", 32'(bus0.busy), 32'd0);
        check("post-rst ready dut1", 32'(bus1.instr_ready), 32'd1);

        // ADD with full field check
        valid = 1'b1;
        instr = mk(OP_ADD, 3'd5, 3'd2, 3'd3, 8'hAA, 8'h55);
        #1;
        check("add ready N", 32'(bus0.instr_ready), 32'd1);
        cyc();
        valid = 1'b0;
        instr = '0;
        #1;
        check("add alu_ctrl", 32'(bus0.alu_ctrl), 32'd1);
        check("add rd", 32'(bus0.rd), 32'd5);
        check("add r1", 32'(bus0.r1), 32'd2);
        check("add r2", 32'(bus0.r2), 32'd3);
        check("add i1", 32'(bus0.i1), 32'hAA);
        check("add i2", 32'(bus0.i2), 32'h55);
        check("add ready N+1", 32'(bus0.instr_ready), 32'd0);
        check("add busy N+1", 32'(bus0.busy), 32'd1);
        check("add pulses N+1", 32'(p0), 32'd0);
        cyc();
        check("add pulses N+2", 32'(p0), 32'd0);
        cyc();
        check("add pulses N+3", 32'(p0), 32'(P_RWE));
        cyc();
        check("add pulses N+4", 32'(p0), 32'd0);
        check("add ready N+4", 32'(bus0.instr_ready), 32'd1);
        check("add hold alu_ctrl", 32'(bus0.alu_ctrl), 32'd1);
        check("add hold i1", 32'(bus0.i1), 32'hAA);

        // Remaining single-cycle opcodes
        run_short("sub",   OP_SUB,   ALU_SUB,  P_RWE);
        run_short("mov",   OP_MOV,   ALU_NONE, P_RWE2);
        run_short("and",   OP_AND,   ALU_AND,  P_RWE);
        run_short("or",    OP_OR,    ALU_OR,   P_RWE);
        run_short("load",  OP_LOAD,  ALU_NONE, P_RWE);
        run_short("store", OP_STORE, ALU_NONE, P_MWE);

        // Illegal and NOP
        run_two("ill3f", 6'h3F, P_ILL);
        run_two("ill10", 6'd10, P_ILL);
        run_two("nop",   OP_NOP, 6'd0);

        // DIV: dut0 finishes on done, dut1 times out after 8 WAIT cycles
        valid = 1'b1;
        instr = mk(OP_DIV, 3'd4, 3'd1, 3'd2, 8'h10, 8'h20);
        #1;
        cyc();
        valid = 1'b0;
        #1;
        check("div pulses N+1", 32'(p0), 32'd0);
        cyc();
        done0 = 1'b1;
        done1 = 1'b1;
        #1;
        check("div start N+2", 32'(p0), 32'(P_START));
        check("div dut1 start N+2", 32'(p1), 32'(P_START));
        check("div alu_ctrl", 32'(bus0.alu_ctrl), 32'd4);
        for (int c = 3; c <= 13; c++) begin
            cyc();
            done0 = (c == 12);
            done1 = (c == 12);
            #1;
            check($sformatf("div dut0 pulses N+%0d", c), 32'(p0), (c == 13) ? 32'(P_RWE) : 32'd0);
            check($sformatf("div dut1 pulses N+%0d", c), 32'(p1), (c == 10) ? 32'(P_FLT) : 32'd0);
            if (c == 11) check("div dut1 ready after fault", 32'(bus1.instr_ready), 32'd1);
            if (c == 13) check("div dut0 busy WB", 32'(bus0.busy), 32'd1);
        end
        done0 = 1'b0;
        done1 = 1'b0;
        cyc();
        check("div dut0 ready N+14", 32'(bus0.instr_ready), 32'd1);

        // MUL: multi-cycle on dut0, single-cycle on dut1
        valid = 1'b1;
        instr = mk(OP_MUL, 3'd7, 3'd1, 3'd1, 8'h03, 8'h04);
        #1;
        cyc();
        valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) cyc();
            done0 = (c == 4);
            #1;
            check($sformatf("mul dut0 pulses N+%0d", c), 32'(p0),
                  (c == 2) ? 32'(P_START) : (c == 5) ? 32'(P_RWE) : 32'd0);
            check($sformatf("mul dut1 pulses N+%0d", c), 32'(p1), (c == 3) ? 32'(P_RWE) : 32'd0);
        end
        done0 = 1'b0;
        check("mul dut0 ready", 32'(bus0.instr_ready), 32'd1);
        check("mul dut1 ready", 32'(bus1.instr_ready), 32'd1);

        // Reset while waiting on the ALU
        valid = 1'b1;
        instr = mk(OP_DIV, 3'd6, 3'd5, 3'd4, 8'h77, 8'h66);
        #1;
        cyc();
        valid = 1'b0;
        cyc();
        cyc();
        cyc();
        check("rstwait busy before", 32'(bus0.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rstwait pulses in rst", 32'(p0), 32'd0);
        check("rstwait busy in rst", 32'(bus0.busy), 32'd0);
        check("rstwait ready in rst", 32'(bus0.instr_ready), 32'd0);
        cyc();
        rst   = 1'b0;
        done0 = 1'b1;
        done1 = 1'b1;
        #1;
        check("rstwait ready after", 32'(bus0.instr_ready), 32'd1);
        check("rstwait busy after", 32'(bus0.busy), 32'd0);
        check("rstwait alu_ctrl cleared", 32'(bus0.alu_ctrl), 32'd0);
        check("rstwait pulses after", 32'(p0), 32'd0);
        cyc();
        done0 = 1'b0;
        done1 = 1'b0;
        #1;
        check("rstwait no late strobe", 32'(p0), 32'd0);
        check("rstwait dut1 no late strobe", 32'(p1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Multi-cycle, parametrised successor to the single-cycle decoder.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and registers the decoded fields.
- Sequences IDLE/DECODE/EXEC/WAIT/WB, starting the multi-cycle ALU (DIV/MUL) and waiting for it to finish.
- Emits one-cycle register-file and memory write strobes. Sits between instruction fetch and the datapath (regfile, ALU, data memory).

Parameters:
INSTR_W, 32, instruction width; must satisfy 6+3*REG_AW+2*IMM_W <= INSTR_W
REG_AW, 3, register address width
IMM_W, 8, width of each immediate field
MUL_MULTI, 1, 1: MUL uses the ALU start/done handshake; 0: MUL is single-cycle
WAIT_MAX, 64, cycles allowed in WAIT before fault

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction available
instr_ready  out  1  block can accept an instruction
instr  in  INSTR_W  instruction word
alu_ctrl  out  6  ALU operation code
r1  out  REG_AW  source register 1
r2  out  REG_AW  source register 2
rd  out  REG_AW  destination register
i1  out  IMM_W  immediate 1
i2  out  IMM_W  immediate 2
alu_start  out  1  one-cycle start pulse to the multi-cycle ALU
alu_done  in  1  multi-cycle ALU result valid
rwe  out  1  regfile write strobe (ALU result)
rwe2  out  1  regfile write strobe (MOV immediate path)
mwe  out  1  data-memory write strobe
illegal  out  1  one-cycle pulse: undefined opcode
fault  out  1  one-cycle pulse: WAIT timeout
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Field layout, MSB to LSB: opcode[6], rd, r1, r2 (REG_AW each), i1, i2 (IMM_W each). Unused bits are ignored.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 MOV, 4 DIV, 5 MUL, 6 AND, 7 OR
  - 8 LOAD (alu_ctrl=0, rwe)
  - 9 STORE (alu_ctrl=0, mwe)
  - all other values are illegal.
- alu_ctrl equals the opcode for opcodes 1,2,4-7 and is 0 otherwise.
- Reset: state IDLE; all outputs 0, including instr_ready during the reset cycle; counter 0. A reset mid-operation abandons the instruction and produces no write strobe.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, capture instr and go to DECODE. instr_ready=0 in every other state.
- DECODE (1 cycle): register alu_ctrl, r1, r2, rd, i1, i2. These hold from EXEC through WB and until the next capture.
  - Illegal opcode: illegal=1 for this cycle, then IDLE.
  - NOP: go to IDLE.
  - Otherwise: go to EXEC.
- EXEC (1 cycle):
  - DIV, or MUL with MUL_MULTI=1: alu_start=1 for exactly this cycle, then WAIT.
  - Otherwise: go to WB.
- WAIT:
  - Counter increments each cycle.
  - alu_done=1 goes to WB; done takes priority over timeout in the same cycle.
  - counter==WAIT_MAX-1 without done: fault=1 for one cycle, then IDLE, no strobes.
  - alu_done is ignored outside WAIT.
- WB (1 cycle), exactly one strobe:
  - rwe for ADD, SUB, DIV, MUL, AND, OR, LOAD
  - rwe2 for MOV
  - mwe for STORE
  - Then IDLE.
- Latency for single-cycle ops: handshake at cycle N, strobe at N+3, instr_ready again at N+4. Throughput is one instruction per 4 cycles.
- Multi-cycle ops: strobe one cycle after the alu_done cycle.
- Strobes, alu_start, illegal and fault are never high simultaneously.

Decomposition:
- Package cu_pkg: opcode enum (NOP..STORE), ALU code constants, FSM state enum.
- Sub-module cu_field_decode (combinational): slices fields from the captured word and classifies the opcode (legal, multicycle, write-strobe select).
- control_unit_mc holds the FSM, the WAIT counter and the output registers.

Test Plan:
- Reset: rst high 2 cycles → all outputs 0. Release → instr_ready=1 next cycle, busy=0.
- ADD: instr with opcode 1, rd=5, r1=2, r2=3, i1=0xAA, i2=0x55 accepted at cycle N → alu_ctrl=1, rd=5, r1=2, r2=3, i1=0xAA, i2=0x55 from N+1; rwe=1 only at N+3; instr_ready=1 at N+4.
- DIV: alu_start pulse at N+2; alu_done asserted 10 cycles later → rwe one cycle after done. alu_done asserted early in EXEC → ignored.
- MOV and STORE: rwe2=1 / mwe=1 at N+3, the other two strobes stay 0. MUL with MUL_MULTI=0 → rwe at N+3, no alu_start.
- Illegal and NOP: opcode 0x3F → illegal pulse at N+1, no strobes, instr_ready at N+2. NOP → no pulses, instr_ready at N+2.
- Timeout and reset: DIV with alu_done never asserted, WAIT_MAX=8 → fault pulse after 8 WAIT cycles, no rwe. rst asserted during WAIT → IDLE next cycle, no strobes.
